quadratic_eq_arbiter: RTL and testbench

Round-robin arbiter that shares one quadratic_eq evaluator (resultado = a*x^2 + b*x + c) among N_REQ requesters. Per request it latches the requester's operands, drives the evaluator's inicio/pronto handshake, and returns the 16-bit result with a one-cycle completion strobe. It sits between the requesters and the single evaluator instance.

---
 rtl/quadratic_eq_arbiter.sv | 167 ++++++++++++++++
 tb/tb_quadratic_eq_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quadratic_eq_arbiter.sv
// quadratic_eq_arbiter
//   Round-robin arbiter sharing one quadratic evaluator
//   (resultado = a*x^2 + b*x + c) among N_REQ requesters.
//   Latches the winner's operands, runs the eq_inicio/eq_pronto handshake,
//   returns the result and pulses a one-hot completion strobe.
//
// Ports
//   clock, reset         : system clock, synchronous active-high reset
//   pedido[N_REQ]        : request levels
//   req_x/a/b/c          : packed operands, requester i in slice i
//   concluido[N_REQ]     : one-hot, one-cycle completion strobe
//   resultado[16]        : last result, held until the next completion
//   ocupado              : high from grant until completion
//   concedido[IW]        : current / last granted requester
//   eq_x/a/b/c, eq_inicio: evaluator operands and start level
//   eq_pronto, eq_resultado : evaluator done level and result
//   erro                 : (QEA_TIMEOUT_EN only) pulses with concluido on timeout
//
// Build option
//   QEA_TIMEOUT_EN : adds a watchdog of TIMEOUT cycles in CALCULA and the erro port.
module quadratic_eq_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      pedido,
  input  logic [8*N_REQ-1:0]    req_x,
  input  logic [16*N_REQ-1:0]   req_a,
  input  logic [16*N_REQ-1:0]   req_b,
  input  logic [16*N_REQ-1:0]   req_c,
  output logic [N_REQ-1:0]      concluido,
  output logic [15:0]           resultado,
  output logic                  ocupado,
  output logic [IW-1:0]         concedido,
  output logic [7:0]            eq_x,
  output logic [15:0]           eq_a,
  output logic [15:0]           eq_b,
  output logic [15:0]           eq_c,
  output logic                  eq_inicio,
  input  logic                  eq_pronto,
`ifdef QEA_TIMEOUT_EN
  output logic                  erro,
`endif
  input  logic [15:0]           eq_resultado
);

  typedef enum logic [1:0] {OCIOSO, CALCULA, ENTREGA} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr;
  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic            start, finish, expire;

  // First set request after ptr, wrapping modulo N_REQ; ptr itself is
  // searched last so the requester just served has lowest priority.
  always_comb begin
    int j;
    j       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (!gnt_any && pedido[j]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

`ifdef QEA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic          timed_out;
  // cnt holds (cycles already spent in CALCULA); the TIMEOUT-th cycle expires.
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
`else
  wire unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) state_q <= OCIOSO;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    case (state_q)
      OCIOSO: begin
        // A stale pronto from the previous job must drop before a new start.
        if (gnt_any && !eq_pronto) begin
          state_d = CALCULA;
          start   = 1'b1;
        end
      end
      CALCULA: begin
        if (eq_pronto) begin
          state_d = ENTREGA;
          finish  = 1'b1;
        end
`ifdef QEA_TIMEOUT_EN
        else if (timed_out) begin
          state_d = ENTREGA;
          expire  = 1'b1;
        end
`endif
      end
      ENTREGA: state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      concluido <= '0;
      resultado <= '0;
      ocupado   <= 1'b0;
      concedido <= '0;
      eq_inicio <= 1'b0;
      eq_x      <= '0;
      eq_a      <= '0;
      eq_b      <= '0;
      eq_c      <= '0;
      ptr       <= IW'(N_REQ - 1);
    end else begin
      if (start) begin
        eq_x      <= req_x[8*int'(gnt_idx) +: 8];
        eq_a      <= req_a[16*int'(gnt_idx) +: 16];
        eq_b      <= req_b[16*int'(gnt_idx) +: 16];
        eq_c      <= req_c[16*int'(gnt_idx) +: 16];
        concedido <= gnt_idx;
        ocupado   <= 1'b1;
        eq_inicio <= 1'b1;
      end
      if (finish || expire) begin
        resultado <= finish ? eq_resultado : 16'hFFFF;
        eq_inicio <= 1'b0;
        concluido <= {{(N_REQ-1){1'b0}}, 1'b1} << concedido;
      end
      if (state_q == ENTREGA) begin
        concluido <= '0;
        ocupado   <= 1'b0;
        ptr       <= concedido;
      end
    end
  end

`ifdef QEA_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      erro <= 1'b0;
    end else begin
      if (start)                  cnt <= '0;
      else if (state_q == CALCULA) cnt <= cnt + 1'b1;
      if (expire)                  erro <= 1'b1;
      else if (state_q == ENTREGA) erro <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_quadratic_eq_arbiter.sv
module tb_quadratic_eq_arbiter;
  localparam int N = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  pedido = '0;
  logic [8*N-1:0]  req_x = '0;
  logic [16*N-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [N-1:0]  concluido;
  logic [15:0]   resultado;
  logic          ocupado;
  logic [1:0]    concedido;
  logic [7:0]    eq_x;
  logic [15:0]   eq_a, eq_b, eq_c;
  logic          eq_inicio;
  logic          eq_pronto = 1'b0;
  logic [15:0]   eq_resultado = '0;
`ifdef QEA_TIMEOUT_EN
  logic          erro;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  bit hang = 1'b0;
  int scnt = 0;

  always #5 clock = ~clock;

  quadratic_eq_arbiter #(.N_REQ(N), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .pedido(pedido),
    .req_x(req_x), .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .concluido(concluido), .resultado(resultado), .ocupado(ocupado),
    .concedido(concedido), .eq_x(eq_x), .eq_a(eq_a), .eq_b(eq_b), .eq_c(eq_c),
    .eq_inicio(eq_inicio), .eq_pronto(eq_pronto),
`ifdef QEA_TIMEOUT_EN
    .erro(erro),
`endif
    .eq_resultado(eq_resultado)
  );

  // Evaluator stub: pronto rises 3 edges after it sees inicio, drops when inicio drops.
  always @(posedge clock) begin
    if (eq_inicio !== 1'b1 || hang) begin
      eq_pronto <= 1'b0;
      scnt      <= 0;
    end else if (scnt == 2) begin
      eq_pronto    <= 1'b1;
      eq_resultado <= eq_a * {8'd0, eq_x} * {8'd0, eq_x} + eq_b * {8'd0, eq_x} + eq_c;
    end else begin
      scnt <= scnt + 1;
    end
  end

  task automatic set_req(input int i, input logic [7:0] x, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] c);
    req_x[8*i +: 8]   = x;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_c[16*i +: 16] = c;
  endtask

  task automatic rst_dut();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // Advance negedges until a strobe shows; n = negedges waited, ok=0 on timeout.
  task automatic wait_done(output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      n++;
      if (concluido != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({concluido, resultado, ocupado, concedido, eq_inicio} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: concluido=%b resultado=%h ocupado=%b concedido=%0d inicio=%b, want all 0",
               concluido, resultado, ocupado, concedido, eq_inicio);
    end
    tests_run++;
    if ({eq_x, eq_a, eq_b, eq_c} !== '0) begin
      tests_failed++;
      $display("FAIL reset_operands: x=%h a=%h b=%h c=%h, want 0", eq_x, eq_a, eq_b, eq_c);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_job();
    int n; bit ok;
    set_req(0, 8'd1, 16'd3, 16'd3, 16'd0);
    pedido = 4'b0001;
    @(negedge clock);
    tests_run++;
    if (eq_inicio !== 1'b1 || ocupado !== 1'b1 || concedido !== 2'd0 || eq_x !== 8'd1 || eq_a !== 16'd3) begin
      tests_failed++;
      $display("FAIL single_grant: inicio=%b ocupado=%b concedido=%0d x=%0d a=%0d, want 1 1 0 1 3",
               eq_inicio, ocupado, concedido, eq_x, eq_a);
    end
    pedido = 4'b0000;
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0001 || resultado !== 16'd6) begin
      tests_failed++;
      $display("FAIL single_done: ok=%b concluido=%b resultado=%0d, want 0001 6", ok, concluido, resultado);
    end
    @(negedge clock);
    tests_run++;
    if (concluido !== 4'b0000 || ocupado !== 1'b0 || resultado !== 16'd6) begin
      tests_failed++;
      $display("FAIL single_after: concluido=%b ocupado=%b resultado=%0d, want 0000 0 6",
               concluido, ocupado, resultado);
    end
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    logic [3:0]  exp_c [5];
    logic [15:0] exp_r [5];
    exp_c = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{16'd7, 16'd9, 16'd11, 16'd13, 16'd7};
    rst_dut();
    for (int i = 0; i < 4; i++) set_req(i, 8'd2, 16'd1, 16'(i), 16'd3);
    pedido = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(n, ok);
      tests_run++;
      if (!ok || concluido !== exp_c[k] || resultado !== exp_r[k]) begin
        tests_failed++;
        $display("FAIL rr_%0d: ok=%b concluido=%b resultado=%0d, want %b %0d",
                 k, ok, concluido, resultado, exp_c[k], exp_r[k]);
      end
    end
    pedido = 4'b0000;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_fairness();
    int n; bit ok;
    rst_dut();
    set_req(0, 8'd0, 16'd7, 16'd7, 16'd5);
    set_req(1, 8'd1, 16'd1, 16'd1, 16'd1);
    pedido = 4'b0010;
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0010 || resultado !== 16'd3) begin
      tests_failed++;
      $display("FAIL fair_first: concluido=%b resultado=%0d, want 0010 3", concluido, resultado);
    end
    pedido = 4'b0011;
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0001 || resultado !== 16'd5) begin
      tests_failed++;
      $display("FAIL fair_second: concluido=%b resultado=%0d, want 0001 5", concluido, resultado);
    end
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0010 || resultado !== 16'd3) begin
      tests_failed++;
      $display("FAIL fair_third: concluido=%b resultado=%0d, want 0010 3", concluido, resultado);
    end
    pedido = 4'b0000;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_operand_hold();
    int n; bit ok;
    rst_dut();
    set_req(2, 8'd3, 16'd2, 16'd1, 16'd4);
    pedido = 4'b0100;
    @(negedge clock);
    tests_run++;
    if (eq_inicio !== 1'b1 || concedido !== 2'd2) begin
      tests_failed++;
      $display("FAIL hold_grant: inicio=%b concedido=%0d, want 1 2", eq_inicio, concedido);
    end
    set_req(2, 8'd9, 16'd9, 16'd9, 16'd9);
    pedido = 4'b0000;
    @(negedge clock);
    tests_run++;
    if (eq_x !== 8'd3 || eq_a !== 16'd2 || eq_b !== 16'd1 || eq_c !== 16'd4) begin
      tests_failed++;
      $display("FAIL hold_operands: x=%0d a=%0d b=%0d c=%0d, want 3 2 1 4", eq_x, eq_a, eq_b, eq_c);
    end
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0100 || resultado !== 16'd25) begin
      tests_failed++;
      $display("FAIL hold_result: concluido=%b resultado=%0d, want 0100 25", concluido, resultado);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    hang = 1'b1;
    set_req(3, 8'd1, 16'd1, 16'd1, 16'd1);
    pedido = 4'b1000;
    @(negedge clock);
    pedido = 4'b0000;
    repeat (3) @(negedge clock);
    tests_run++;
    if (eq_inicio !== 1'b1 || ocupado !== 1'b1 || concedido !== 2'd3) begin
      tests_failed++;
      $display("FAIL mid_busy: inicio=%b ocupado=%b concedido=%0d, want 1 1 3", eq_inicio, ocupado, concedido);
    end
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (eq_inicio !== 1'b0 || ocupado !== 1'b0 || concluido !== 4'b0000 || resultado !== 16'd0 || concedido !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: inicio=%b ocupado=%b concluido=%b resultado=%0d concedido=%0d, want all 0",
               eq_inicio, ocupado, concluido, resultado, concedido);
    end
    reset = 1'b0;
    hang = 1'b0;
    set_req(0, 8'd0, 16'd0, 16'd0, 16'd42);
    pedido = 4'b1111;
    @(negedge clock);
    tests_run++;
    if (eq_inicio !== 1'b1 || concedido !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_regrant: inicio=%b concedido=%0d, want 1 0", eq_inicio, concedido);
    end
    pedido = 4'b0000;
    wait_done(n, ok);
    tests_run++;
    if (!ok || concluido !== 4'b0001 || resultado !== 16'd42) begin
      tests_failed++;
      $display("FAIL mid_done: concluido=%b resultado=%0d, want 0001 42", concluido, resultado);
    end
    repeat (2) @(negedge clock);
  endtask

`ifdef QEA_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok;
    hang = 1'b1;
    rst_dut();
    pedido = 4'b0001;
    @(negedge clock);
    pedido = 4'b0000;
    wait_done(n, ok);
    tests_run++;
    if (!ok || n != 8 || erro !== 1'b1 || concluido !== 4'b0001 || resultado !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL timeout: ok=%b cycles=%0d erro=%b concluido=%b resultado=%h, want 8 1 0001 ffff",
               ok, n, erro, concluido, resultado);
    end
    @(negedge clock);
    tests_run++;
    if (erro !== 1'b0 || ocupado !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: erro=%b ocupado=%b, want 0 0", erro, ocupado);
    end
    hang = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_fairness();
    test_operand_hold();
    test_reset_mid();
`ifdef QEA_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
